neighbor_builder: RTL and testbench
===================================

// Module: neighbor_builder
// PURPOSE
//  Builds the per-vertex neighbor table in RAM_NBR from the face list in RAM_OBJ; averager consumes it.
//  Vertex v (0-based) owns slot base v*MAX_NEIGHBOR_COUNT: word 0 = count, words 1..count = 1-based neighbor idx.
//  RAM_OBJ: vertex v at v*3+1..v*3+3; faces from F0=vertex_count*3+1, face f = three 1-based indices at F0+3f..+2.
//  Run once per subdivision pass, before averager is started.
// PARAMETERS
//  MAX_NEIGHBOR_COUNT  10  words per slot (count + up to MAX_NEIGHBOR_COUNT-1 neighbors)
//  ADDR_WIDTH          9   RAM address width; addresses computed 32-bit, truncated
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous active-high reset
//  start          in   1   begin build; sampled in IDLE only
//  vertex_count   in   32  vertices in mesh
//  face_count     in   32  triangles in mesh
//  RAM_OBJ_Do     in   32  object RAM read data
//  RAM_NBR_Do     in   32  neighbor RAM read data
//  RAM_OBJ_EN     out  1   object RAM enable
//  RAM_OBJ_A      out  AW  object RAM address
//  RAM_OBJ_WE     out  4   object RAM byte write enable (always 0)
//  RAM_OBJ_Di     out  32  object RAM write data (always 0)
//  RAM_NBR_EN     out  1   neighbor RAM enable
//  RAM_NBR_A      out  AW  neighbor RAM address
//  RAM_NBR_WE     out  4   neighbor RAM byte write enable (4'b1111 or 0)
//  RAM_NBR_Di     out  32  neighbor RAM write data
//  busy           out  1   high from cycle after start until done
//  done           out  1   one-cycle pulse on completion
//  overflow       out  1   sticky: a neighbor was dropped (slot full)
//  index_err      out  1   sticky: face with index 0 or >vertex_count skipped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; rst mid-run aborts immediately, no further writes. Flags cleared on start.
//  RAMs: 1-cycle read latency; Do valid cycle after A/EN. Writes commit on the edge WE is high.
//  States: IDLE->CLEAR->FACE_RD->CNT_RD->SCAN->APPEND->(CNT_RD | FACE_RD | DONE)->IDLE.
//  IDLE: wait start. vertex_count==0 -> DONE directly. face_count==0 -> CLEAR then DONE.
//  CLEAR: write 0 to v*MAX_NEIGHBOR_COUNT, v=0..vertex_count-1, one write/cycle.
//  FACE_RD: read 3 indices (a,b,c) for face f, 3 addr cycles + 1 latency. Any index 0 or >vertex_count:
//   set index_err, skip face. a==b etc. not checked beyond: self-pairs (x,x) never inserted.
//  Insertions per face, fixed order: into a: b,c; into b: a,c; into c: a,b (6 pair ops).
//  CNT_RD: read count of owner slot. SCAN: read words 1..count, compare with candidate;
//   match -> pair done, no write. count==0 -> skip SCAN.
//  APPEND: if count < MAX_NEIGHBOR_COUNT-1: write candidate to word count+1, next cycle write count+1
//   to word 0; else set overflow, no write. Counts never exceed MAX_NEIGHBOR_COUNT-1.
//  After 6th pair: f+1; f==face_count -> DONE: busy 0, done pulse 1 cycle, -> IDLE.
//  start ignored while busy. Neighbor order in slot = first-insertion order.
// TESTING
//  Tri: vc=3 fc=1 face(1,2,3) -> NBR[0..2]=2,2,3; NBR[10..12]=2,1,3; NBR[20..22]=2,1,2; flags 0.
//  Quad: vc=4 fc=2 faces(1,2,3),(1,3,4) -> slot0=3:[2,3,4], slot2=3:[1,2,4], slot1=2:[1,3], slot3=2:[1,3].
//  Overflow: MAX_NEIGHBOR_COUNT=3, quad above -> slot0=2:[2,3], slot2=2:[1,2], overflow=1.
//  Bad index: vc=3 fc=2 faces(1,2,3),(0,2,3) -> same as Tri, index_err=1, done pulses.
//  Stale clear: prefill NBR with 0xDEAD, vc=4 fc=0 -> words 0,10,20,30 = 0, done after clear.
//  Reset mid-SCAN on Quad -> next cycle busy=0, NBR_WE=0; restart completes Quad result.

Source files
------------

// File: rtl/neighbor_builder.sv
// Builds the per-vertex neighbor table in RAM_NBR from the triangle list in RAM_OBJ.
// Each vertex slot holds a count word followed by first-insertion-ordered 1-based neighbor indices.
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [31:0]           RAM_OBJ_Di,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  index_err,
    output logic [2:0]            state_dbg
);
    localparam logic [31:0] SLOT_WORDS = 32'(MAX_NEIGHBOR_COUNT);
    localparam logic [31:0] SLOT_CAP   = SLOT_WORDS - 32'd1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FACE_RD = 3'd2,
        CNT_RD  = 3'd3,
        SCAN    = 3'd4,
        APPEND  = 3'd5,
        WR_CNT  = 3'd6,
        DONE    = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] vc_q, vc_d;
    logic [31:0] fc_q, fc_d;
    logic [31:0] face_idx_q, face_idx_d;
    logic [31:0] face_addr_q, face_addr_d;
    logic [31:0] clr_v_q, clr_v_d;
    logic [31:0] clr_addr_q, clr_addr_d;
    logic [31:0] step_q, step_d;
    logic [31:0] idx_a_q, idx_a_d;
    logic [31:0] idx_b_q, idx_b_d;
    logic [31:0] idx_c_q, idx_c_d;
    logic [2:0]  pair_q, pair_d;
    logic [31:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        index_err_q, index_err_d;

    logic [31:0] owner;
    logic [31:0] cand;
    logic [31:0] owner_base;
    logic [31:0] obj_addr;
    logic [31:0] nbr_addr;
    logic        idx_bad;
    logic        pair_done;
    logic        face_done;

    // Six ordered insertions per face: into a: b,c; into b: a,c; into c: a,b.
    always_comb begin
        owner = idx_a_q;
        cand  = idx_b_q;
        case (pair_q)
            3'd0:    begin owner = idx_a_q; cand = idx_b_q; end
            3'd1:    begin owner = idx_a_q; cand = idx_c_q; end
            3'd2:    begin owner = idx_b_q; cand = idx_a_q; end
            3'd3:    begin owner = idx_b_q; cand = idx_c_q; end
            3'd4:    begin owner = idx_c_q; cand = idx_a_q; end
            default: begin owner = idx_c_q; cand = idx_b_q; end
        endcase
    end

    assign owner_base = (owner - 32'd1) * SLOT_WORDS;

    // The third index arrives on RAM_OBJ_Do in the same cycle the face is validated.
    assign idx_bad = (idx_a_q == 32'd0) || (idx_a_q > vc_q) ||
                     (idx_b_q == 32'd0) || (idx_b_q > vc_q) ||
                     (RAM_OBJ_Do == 32'd0) || (RAM_OBJ_Do > vc_q);

    always_comb begin
        state_d     = state_q;
        vc_d        = vc_q;
        fc_d        = fc_q;
        face_idx_d  = face_idx_q;
        face_addr_d = face_addr_q;
        clr_v_d     = clr_v_q;
        clr_addr_d  = clr_addr_q;
        step_d      = step_q;
        idx_a_d     = idx_a_q;
        idx_b_d     = idx_b_q;
        idx_c_d     = idx_c_q;
        pair_d      = pair_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        index_err_d = index_err_q;
        pair_done   = 1'b0;
        face_done   = 1'b0;
        obj_addr    = 32'd0;
        nbr_addr    = 32'd0;
        RAM_OBJ_EN  = 1'b0;
        RAM_NBR_EN  = 1'b0;
        RAM_NBR_WE  = 4'b0000;
        RAM_NBR_Di  = 32'd0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vc_d        = vertex_count;
                    fc_d        = face_count;
                    overflow_d  = 1'b0;
                    index_err_d = 1'b0;
                    face_idx_d  = 32'd0;
                    face_addr_d = vertex_count * 32'd3 + 32'd1;
                    clr_v_d     = 32'd0;
                    clr_addr_d  = 32'd0;
                    step_d      = 32'd0;
                    state_d     = (vertex_count == 32'd0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                nbr_addr   = clr_addr_q;
                clr_v_d    = clr_v_q + 32'd1;
                clr_addr_d = clr_addr_q + SLOT_WORDS;
                if (clr_v_q + 32'd1 == vc_q) begin
                    step_d  = 32'd0;
                    state_d = (fc_q == 32'd0) ? DONE : FACE_RD;
                end
            end
            FACE_RD: begin
                if (step_q < 32'd3) begin
                    RAM_OBJ_EN = 1'b1;
                    obj_addr   = face_addr_q + step_q;
                end
                if (step_q == 32'd1) idx_a_d = RAM_OBJ_Do;
                if (step_q == 32'd2) idx_b_d = RAM_OBJ_Do;
                step_d = step_q + 32'd1;
                if (step_q == 32'd3) begin
                    idx_c_d = RAM_OBJ_Do;
                    if (idx_bad) begin
                        index_err_d = 1'b1;
                        face_done   = 1'b1;
                    end else begin
                        pair_d  = 3'd0;
                        step_d  = 32'd0;
                        state_d = CNT_RD;
                    end
                end
            end
            CNT_RD: begin
                if (step_q == 32'd0) begin
                    if (owner == cand) begin
                        pair_done = 1'b1;
                    end else begin
                        RAM_NBR_EN = 1'b1;
                        nbr_addr   = owner_base;
                        step_d     = 32'd1;
                    end
                end else begin
                    count_d = RAM_NBR_Do;
                    step_d  = 32'd0;
                    state_d = (RAM_NBR_Do == 32'd0) ? APPEND : SCAN;
                end
            end
            SCAN: begin
                // Pipelined: issue word step+1 while comparing word step returned this cycle.
                if (step_q < count_q) begin
                    RAM_NBR_EN = 1'b1;
                    nbr_addr   = owner_base + step_q + 32'd1;
                end
                step_d = step_q + 32'd1;
                if (step_q != 32'd0 && RAM_NBR_Do == cand) begin
                    pair_done = 1'b1;
                end else if (step_q >= count_q) begin
                    step_d  = 32'd0;
                    state_d = APPEND;
                end
            end
            APPEND: begin
                if (count_q < SLOT_CAP) begin
                    RAM_NBR_EN = 1'b1;
                    RAM_NBR_WE = 4'b1111;
                    nbr_addr   = owner_base + count_q + 32'd1;
                    RAM_NBR_Di = cand;
                    state_d    = WR_CNT;
                end else begin
                    overflow_d = 1'b1;
                    pair_done  = 1'b1;
                end
            end
            WR_CNT: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                nbr_addr   = owner_base;
                RAM_NBR_Di = count_q + 32'd1;
                pair_done  = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pair_done) begin
            if (pair_q == 3'd5) begin
                face_done = 1'b1;
            end else begin
                pair_d  = pair_q + 3'd1;
                step_d  = 32'd0;
                state_d = CNT_RD;
            end
        end

        if (face_done) begin
            face_idx_d  = face_idx_q + 32'd1;
            face_addr_d = face_addr_q + 32'd3;
            step_d      = 32'd0;
            state_d     = (face_idx_q + 32'd1 == fc_q) ? DONE : FACE_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vc_q        <= 32'd0;
            fc_q        <= 32'd0;
            face_idx_q  <= 32'd0;
            face_addr_q <= 32'd0;
            clr_v_q     <= 32'd0;
            clr_addr_q  <= 32'd0;
            step_q      <= 32'd0;
            idx_a_q     <= 32'd0;
            idx_b_q     <= 32'd0;
            idx_c_q     <= 32'd0;
            pair_q      <= 3'd0;
            count_q     <= 32'd0;
            overflow_q  <= 1'b0;
            index_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vc_q        <= vc_d;
            fc_q        <= fc_d;
            face_idx_q  <= face_idx_d;
            face_addr_q <= face_addr_d;
            clr_v_q     <= clr_v_d;
            clr_addr_q  <= clr_addr_d;
            step_q      <= step_d;
            idx_a_q     <= idx_a_d;
            idx_b_q     <= idx_b_d;
            idx_c_q     <= idx_c_d;
            pair_q      <= pair_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            index_err_q <= index_err_d;
        end
    end

    assign RAM_OBJ_A  = obj_addr[ADDR_WIDTH-1:0];
    assign RAM_NBR_A  = nbr_addr[ADDR_WIDTH-1:0];
    assign RAM_OBJ_WE = 4'b0000;
    assign RAM_OBJ_Di = 32'd0;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign overflow   = overflow_q;
    assign index_err  = index_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_neighbor_builder.sv
// Bench for neighbor_builder: two instances (default slot size and slot size 3) on modelled RAMs,
// checked against a set-based neighbor model plus hand-computed table contents.
module tb_neighbor_builder;
    localparam int AW   = 9;
    localparam int MEMW = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic prefill = 1'b0;
    logic [31:0] vertex_count = 32'd0;
    logic [31:0] face_count = 32'd0;

    always #5 clk = ~clk;

    logic [31:0] obj_mem [MEMW];
    logic [31:0] nbr_a [MEMW];
    logic [31:0] nbr_b [MEMW];

    logic           a_obj_en, a_nbr_en, b_obj_en, b_nbr_en;
    logic [AW-1:0]  a_obj_a, a_nbr_a, b_obj_a, b_nbr_a;
    logic [3:0]     a_obj_we, a_nbr_we, b_obj_we, b_nbr_we;
    logic [31:0]    a_obj_di, a_nbr_di, b_obj_di, b_nbr_di;
    logic [31:0]    a_obj_do = 32'd0, a_nbr_do = 32'd0, b_obj_do = 32'd0, b_nbr_do = 32'd0;
    logic           a_busy, a_done, a_ovf, a_ierr, b_busy, b_done, b_ovf, b_ierr;
    logic [2:0]     a_state, b_state;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start_a),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(a_obj_do), .RAM_NBR_Do(a_nbr_do),
        .RAM_OBJ_EN(a_obj_en), .RAM_OBJ_A(a_obj_a), .RAM_OBJ_WE(a_obj_we), .RAM_OBJ_Di(a_obj_di),
        .RAM_NBR_EN(a_nbr_en), .RAM_NBR_A(a_nbr_a), .RAM_NBR_WE(a_nbr_we), .RAM_NBR_Di(a_nbr_di),
        .busy(a_busy), .done(a_done), .overflow(a_ovf), .index_err(a_ierr), .state_dbg(a_state)
    );

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(3), .ADDR_WIDTH(AW)) dut_small (
        .clk(clk), .rst(rst), .start(start_b),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(b_obj_do), .RAM_NBR_Do(b_nbr_do),
        .RAM_OBJ_EN(b_obj_en), .RAM_OBJ_A(b_obj_a), .RAM_OBJ_WE(b_obj_we), .RAM_OBJ_Di(b_obj_di),
        .RAM_NBR_EN(b_nbr_en), .RAM_NBR_A(b_nbr_a), .RAM_NBR_WE(b_nbr_we), .RAM_NBR_Di(b_nbr_di),
        .busy(b_busy), .done(b_done), .overflow(b_ovf), .index_err(b_ierr), .state_dbg(b_state)
    );

    // RAM models: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (a_obj_en) a_obj_do <= obj_mem[a_obj_a];
        if (b_obj_en) b_obj_do <= obj_mem[b_obj_a];
        if (a_nbr_en) a_nbr_do <= nbr_a[a_nbr_a];
        if (b_nbr_en) b_nbr_do <= nbr_b[b_nbr_a];
        if (prefill) begin
            for (int i = 0; i < MEMW; i++) nbr_a[i] <= 32'hDEAD;
        end else if (a_nbr_en && a_nbr_we == 4'hF) begin
            nbr_a[a_nbr_a] <= a_nbr_di;
        end
        if (b_nbr_en && b_nbr_we == 4'hF) nbr_b[b_nbr_a] <= b_nbr_di;
    end

    logic sel = 1'b0;
    logic in_run = 1'b0;
    int   run_vc = 0;
    int   run_max = 10;
    wire        sel_busy   = sel ? b_busy : a_busy;
    wire        sel_done   = sel ? b_done : a_done;
    wire        sel_ovf    = sel ? b_ovf : a_ovf;
    wire        sel_ierr   = sel ? b_ierr : a_ierr;
    wire [3:0]  sel_nbr_we = sel ? b_nbr_we : a_nbr_we;
    wire [AW-1:0] sel_nbr_a = sel ? b_nbr_a : a_nbr_a;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle invariants on every meaningful cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("obj ram never written", {a_obj_we, b_obj_we, 24'd0} | a_obj_di | b_obj_di, 32'd0);
            chk("done excludes busy", 32'(sel_done && sel_busy), 32'd0);
            if (in_run && sel_nbr_we != 4'd0)
                chk("write inside table", 32'(int'(sel_nbr_a) < run_vc * run_max), 32'd1);
        end
    end

    int f_a[4];
    int f_b[4];
    int f_c[4];

    task automatic load_mesh(input int vc, input int nf);
        for (int i = 0; i < MEMW; i++) obj_mem[i] = 32'd0;
        for (int v = 0; v < vc; v++)
            for (int k = 1; k <= 3; k++) obj_mem[v * 3 + k] = 32'(100 + v * 3 + k);
        for (int f = 0; f < nf; f++) begin
            obj_mem[vc * 3 + 1 + 3 * f]     = 32'(f_a[f]);
            obj_mem[vc * 3 + 1 + 3 * f + 1] = 32'(f_b[f]);
            obj_mem[vc * 3 + 1 + 3 * f + 2] = 32'(f_c[f]);
        end
    endtask

    task automatic set_face(input int f, input int a, input int b, input int c);
        f_a[f] = a; f_b[f] = b; f_c[f] = c;
    endtask

    // Model: each vertex holds an ordered set of neighbors, capped at maxn-1 entries.
    int m_cnt[8];
    int m_nbr[8][16];
    bit m_ovf;
    bit m_ierr;

    task automatic model(input int vc, input int nf, input int maxn);
        int t[3];
        int ov;
        bit found;
        m_ovf = 0;
        m_ierr = 0;
        for (int v = 0; v < 8; v++) m_cnt[v] = 0;
        for (int f = 0; f < nf; f++) begin
            t[0] = f_a[f]; t[1] = f_b[f]; t[2] = f_c[f];
            if (t[0] < 1 || t[0] > vc || t[1] < 1 || t[1] > vc || t[2] < 1 || t[2] > vc) begin
                m_ierr = 1;
                continue;
            end
            for (int o = 0; o < 3; o++) begin
                for (int c = 0; c < 3; c++) begin
                    if (c == o || t[o] == t[c]) continue;
                    ov = t[o] - 1;
                    found = 0;
                    for (int k = 0; k < m_cnt[ov]; k++) if (m_nbr[ov][k] == t[c]) found = 1;
                    if (!found) begin
                        if (m_cnt[ov] < maxn - 1) begin
                            m_nbr[ov][m_cnt[ov]] = t[c];
                            m_cnt[ov]++;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] rd(input bit use_b, input int addr);
        return use_b ? nbr_b[addr] : nbr_a[addr];
    endfunction

    logic [31:0] exp_q[$];
    int          exp_addr_q[$];

    task automatic run(input bit use_b, input int vc, input int nf, input int maxn, input string tag);
        int n;
        int addr;
        logic [31:0] exp;
        model(vc, nf, maxn);
        sel = use_b;
        run_vc = vc;
        run_max = maxn;
        vertex_count = 32'(vc);
        face_count = 32'(nf);
        @(posedge clk); #1;
        in_run = 1'b1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        chk({tag, " busy after start"}, 32'(sel_busy), (vc > 0) ? 32'd1 : 32'd0);
        n = 0;
        while (!sel_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done within budget"}, 32'(n < 3000), 32'd1);
        chk({tag, " overflow"}, 32'(sel_ovf), 32'(m_ovf));
        chk({tag, " index_err"}, 32'(sel_ierr), 32'(m_ierr));
        @(negedge clk);
        chk({tag, " done is one pulse"}, 32'(sel_done), 32'd0);
        chk({tag, " idle after done"}, 32'(sel_busy), 32'd0);
        in_run = 1'b0;
        for (int v = 0; v < vc; v++) begin
            exp_addr_q.push_back(v * maxn);
            exp_q.push_back(32'(m_cnt[v]));
            for (int k = 0; k < m_cnt[v]; k++) begin
                exp_addr_q.push_back(v * maxn + 1 + k);
                exp_q.push_back(32'(m_nbr[v][k]));
            end
        end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            addr = exp_addr_q.pop_front();
            chk($sformatf("%s nbr[%0d]", tag, addr), rd(use_b, addr), exp);
        end
    endtask

    task automatic lit(input bit use_b, input int addr, input int val, input string tag);
        chk($sformatf("%s literal nbr[%0d]", tag, addr), rd(use_b, addr), 32'(val));
    endtask

    task automatic lit_tri(input string tag);
        lit(0, 0, 2, tag);  lit(0, 1, 2, tag);  lit(0, 2, 3, tag);
        lit(0, 10, 2, tag); lit(0, 11, 1, tag); lit(0, 12, 3, tag);
        lit(0, 20, 2, tag); lit(0, 21, 1, tag); lit(0, 22, 2, tag);
    endtask

    task automatic lit_quad(input string tag);
        lit(0, 0, 3, tag);  lit(0, 1, 2, tag);  lit(0, 2, 3, tag);  lit(0, 3, 4, tag);
        lit(0, 20, 3, tag); lit(0, 21, 1, tag); lit(0, 22, 2, tag); lit(0, 23, 4, tag);
        lit(0, 10, 2, tag); lit(0, 11, 1, tag); lit(0, 12, 3, tag);
        lit(0, 30, 2, tag); lit(0, 31, 1, tag); lit(0, 32, 3, tag);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(a_busy | b_busy), 32'd0);
        chk("reset done", 32'(a_done | b_done), 32'd0);
        chk("reset flags", 32'(a_ovf | a_ierr | b_ovf | b_ierr), 32'd0);
        chk("reset ram enables", 32'({a_obj_en, a_nbr_en, b_obj_en, b_nbr_en}), 32'd0);
        chk("reset nbr we", 32'({a_nbr_we, b_nbr_we}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single triangle
        set_face(0, 1, 2, 3);
        load_mesh(3, 1);
        run(0, 3, 1, 10, "tri");
        lit_tri("tri");
        chk("tri flags literal", 32'({a_ovf, a_ierr}), 32'd0);

        // Two triangles sharing an edge
        set_face(0, 1, 2, 3);
        set_face(1, 1, 3, 4);
        load_mesh(4, 2);
        run(0, 4, 2, 10, "quad");
        lit_quad("quad");

        // Zero and out-of-range indices are skipped
        set_face(0, 1, 2, 3);
        set_face(1, 0, 2, 3);
        set_face(2, 2, 3, 4);
        load_mesh(3, 3);
        run(0, 3, 3, 10, "badidx");
        lit_tri("badidx");
        chk("badidx index_err literal", 32'(a_ierr), 32'd1);

        // No faces: stale slots are cleared; new start clears the sticky flag
        @(posedge clk); #1;
        prefill = 1'b1;
        @(posedge clk); #1;
        prefill = 1'b0;
        load_mesh(4, 0);
        run(0, 4, 0, 10, "stale");
        lit(0, 0, 0, "stale"); lit(0, 10, 0, "stale"); lit(0, 20, 0, "stale"); lit(0, 30, 0, "stale");
        lit(0, 1, 32'hDEAD, "stale");
        chk("stale index_err cleared", 32'(a_ierr), 32'd0);

        // No vertices: done without any work
        run(0, 0, 0, 10, "empty");

        // Reset during a neighbor scan, then rerun
        set_face(0, 1, 2, 3);
        set_face(1, 1, 3, 4);
        load_mesh(4, 2);
        sel = 1'b0;
        run_vc = 4;
        run_max = 10;
        vertex_count = 32'd4;
        face_count = 32'd2;
        @(posedge clk); #1;
        in_run = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(a_nbr_en && a_nbr_we == 4'd0 && (a_nbr_a % 10) != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("scan reached before reset", 32'(n < 3000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-run reset busy", 32'(a_busy), 32'd0);
        chk("mid-run reset nbr we", 32'(a_nbr_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_run = 1'b0;
        run(0, 4, 2, 10, "restart");
        lit_quad("restart");

        // Slots of three words overflow on the quad
        run(1, 4, 2, 3, "ovf");
        lit(1, 0, 2, "ovf"); lit(1, 1, 2, "ovf"); lit(1, 2, 3, "ovf");
        lit(1, 6, 2, "ovf"); lit(1, 7, 1, "ovf"); lit(1, 8, 2, "ovf");
        chk("ovf overflow literal", 32'(b_ovf), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
